lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly downstream of the execute-stage ALU.
- Takes the ALU result X as the effective address, plus rs2 data and funct3, and runs one data-memory transaction over a req/ack handshake.
- Returns formatted load data to writeback, or an error pulse to the trap logic.
- Stalls the pipeline through in_ready while a transaction is outstanding.

Parameters:
- TIMEOUT, 255: maximum REQ cycles without mem_ack before a bus-timeout error; 0 disables the timeout.
- AW, 32: address width (byte address).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EX stage presents a memory op
- in_ready  out  1  LSU idle; op accepted when in_valid && in_ready
- in_store  in  1  1 = store, 0 = load
- in_addr  in  AW  effective address (ALU X)
- in_wdata  in  32  rs2 value for stores
- in_funct3  in  3  RV32I width/sign code
- in_rd  in  5  load destination register
- mem_req  out  1  request, held until ack
- mem_we  out  1  write enable
- mem_addr  out  AW  word-aligned address, {in_addr[AW-1:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte strobes (0000 on loads)
- mem_ack  in  1  memory completes the request this cycle
- mem_rdata  in  32  read word, valid with mem_ack
- wb_valid  out  1  one-cycle pulse: load result valid
- wb_rd  out  5  destination register
- wb_data  out  32  extended load data
- err_valid  out  1  one-cycle pulse: op aborted
- err_cause  out  2  00 illegal funct3, 01 load misaligned, 10 store misaligned, 11 bus timeout
- err_addr  out  AW  faulting in_addr

Behaviour:
- Reset: state IDLE; in_ready=1; mem_req=0, mem_we=0, mem_wstrb=0, wb_valid=0, err_valid=0; counter=0; mem_addr, mem_wdata, wb_data, wb_rd, err_addr, err_cause = 0. All outputs are registered except in_ready = (state==IDLE).
- States: IDLE, REQ.
- IDLE, on accept: the op is checked first.
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store funct3: 000 SB, 001 SH, 010 SW.
  - Halfword needs addr[0]=0; word needs addr[1:0]=00.
  - Illegal or misaligned: stay IDLE; err_valid, err_cause, err_addr asserted the next cycle; no memory access.
  - Otherwise: next cycle mem_req=1, outputs latched, state REQ.
- Store lanes: SB gives wdata={4{b}}, wstrb=0001<<addr[1:0]; SH gives {2{h}}, 0011<<addr[1:0]; SW gives full word, 1111.
- REQ: mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb stay stable until mem_ack is sampled high.
  - On ack: mem_req drops the next cycle and state returns to IDLE.
  - For loads, wb_valid pulses the next cycle with wb_data = rdata >> (8*addr[1:0]), sign- or zero-extended per funct3.
  - Stores produce no wb pulse.
- Latency: accept at cycle 0, mem_req visible at cycle 1; ack at cycle k≥1 gives wb_valid and in_ready at k+1. Minimum load-to-use is 2 cycles.
- Timeout (TIMEOUT>0): the counter increments each REQ cycle with mem_ack=0.
  - When TIMEOUT cycles pass without ack, the LSU drops mem_req, raises err_valid with cause 11, and returns to IDLE.
  - Ack in the expiry cycle wins; no error is raised.
  - The counter clears on every accept.
- mem_ack while IDLE is ignored.
- in_valid while busy is not accepted; EX must hold it.
- rst in any state, including REQ with ack in the same cycle: next cycle is the reset state, with no wb/err pulse.
- Address arithmetic is unsigned and wraps; 0xFFFF_FFFC is a legal word address.

Decomposition:
- lsu_pkg holds:
  - funct3 constants (F3_B/H/W/BU/HU)
  - err_cause codes (ERR_ILLEGAL, ERR_LMIS, ERR_SMIS, ERR_TIMEOUT)
  - state enum (S_IDLE, S_REQ)
- One combinational sub-module, lsu_align, provides:
  - store lane replication and strobe generation
  - load extraction and extension
  - legality/alignment check

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, ack after 3 cycles -> mem_req held 3 cycles with wstrb=1111, mem_addr=0x100; no wb_valid; in_ready high the cycle after ack.
- LB addr=0x203, rdata=0x80FF_7F01, ack immediate -> wb_data=0xFFFF_FF80; LBU gives 0x0000_0080; LH at 0x202 gives 0xFFFF_80FF.
- SH addr=0x302, wdata=0x1234_ABCD -> mem_addr=0x300, mem_wdata=0xABCD_ABCD, wstrb=1100.
- LW addr=0x105 -> no mem_req; err_valid=1, cause=01, err_addr=0x105; funct3=011 load gives cause=00.
- TIMEOUT=4, load with no ack -> mem_req high exactly 4 cycles, err cause=11; repeat with ack in cycle 4 -> normal wb_valid, no error.
- rst asserted mid-REQ (cycle 2, concurrent ack) -> next cycle mem_req=0, wb_valid=0, in_ready=1; a later mem_ack in IDLE is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I width codes, error causes
// and FSM state type.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_ILLEGAL = 2'b00;
    localparam logic [1:0] ERR_LMIS    = 2'b01;
    localparam logic [1:0] ERR_SMIS    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational data path of the LSU: op legality/alignment check, store lane
// replication with byte strobes, and load byte/halfword extraction with extension.
module lsu_align (
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic        o_ok,
    output logic [1:0]  o_cause,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_ldata
);
    import lsu_pkg::*;

    logic        w_legal;
    logic        w_mis;
    logic [31:0] w_shift;

    always_comb begin
        w_legal = 1'b0;
        w_mis   = 1'b0;
        if (i_store) begin
            w_legal = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);
        end else begin
            w_legal = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W) ||
                      (i_funct3 == F3_BU) || (i_funct3 == F3_HU);
        end
        // funct3[1:0] carries the access size for both signed and unsigned loads
        case (i_funct3[1:0])
            2'b01:   w_mis = i_addr_lo[0];
            2'b10:   w_mis = |i_addr_lo;
            default: w_mis = 1'b0;
        endcase
        o_ok    = w_legal && !w_mis;
        o_cause = !w_legal ? ERR_ILLEGAL : (i_store ? ERR_SMIS : ERR_LMIS);
    end

    always_comb begin
        o_wdata = i_wdata;
        o_wstrb = 4'b1111;
        case (i_funct3)
            F3_B: begin
                o_wdata = {4{i_wdata[7:0]}};
                o_wstrb = 4'b0001 << i_addr_lo;
            end
            F3_H: begin
                o_wdata = {2{i_wdata[15:0]}};
                o_wstrb = 4'b0011 << i_addr_lo;
            end
            default: begin
                o_wdata = i_wdata;
                o_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        w_shift = i_rdata >> {i_ld_off, 3'b000};
        o_ldata = w_shift;
        case (i_ld_funct3)
            F3_B:    o_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_BU:   o_ldata = {24'h000000, w_shift[7:0]};
            F3_H:    o_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
            F3_HU:   o_ldata = {16'h0000, w_shift[15:0]};
            default: o_ldata = w_shift;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op from EX, runs it over a req/ack bus
// and returns extended load data to writeback or an error pulse to trap logic.
//   state  | meaning
//   S_IDLE | ready for a new op; in_ready high
//   S_REQ  | request outstanding; waiting for mem_ack or timeout
module lsu #(
    parameter int TIMEOUT = 255,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_store,
    input  logic [AW-1:0] in_addr,
    input  logic [31:0]   in_wdata,
    input  logic [2:0]    in_funct3,
    input  logic [4:0]    in_rd,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic          wb_valid,
    output logic [4:0]    wb_rd,
    output logic [31:0]   wb_data,
    output logic          err_valid,
    output logic [1:0]    err_cause,
    output logic [AW-1:0] err_addr
);
    import lsu_pkg::*;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [31:0]     r_mem_wdata;
    logic [3:0]      r_mem_wstrb;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;
    logic [4:0]      r_rd;
    logic [AW-1:0]   r_addr;
    logic            r_wb_valid;
    logic [4:0]      r_wb_rd;
    logic [31:0]     r_wb_data;
    logic            r_err_valid;
    logic [1:0]      r_err_cause;
    logic [AW-1:0]   r_err_addr;

    logic            w_ok;
    logic [1:0]      w_cause;
    logic [31:0]     w_wdata;
    logic [3:0]      w_wstrb;
    logic [31:0]     w_ldata;
    logic            w_expire;

    lsu_align u_align (
        .i_store     (in_store),
        .i_funct3    (in_funct3),
        .i_addr_lo   (in_addr[1:0]),
        .i_wdata     (in_wdata),
        .i_ld_funct3 (r_f3),
        .i_ld_off    (r_off),
        .i_rdata     (mem_rdata),
        .o_ok        (w_ok),
        .o_cause     (w_cause),
        .o_wdata     (w_wdata),
        .o_wstrb     (w_wstrb),
        .o_ldata     (w_ldata)
    );

    // Ack in the expiry cycle takes priority, so expiry requires mem_ack low
    assign w_expire = (TIMEOUT != 0) && (r_cnt == CNT_LAST) && !mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= 4'b0000;
            r_f3        <= 3'b000;
            r_off       <= 2'b00;
            r_rd        <= 5'd0;
            r_addr      <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= '0;
            r_err_valid <= 1'b0;
            r_err_cause <= 2'b00;
            r_err_addr  <= '0;
        end else begin
            r_wb_valid  <= 1'b0;
            r_err_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_ok) begin
                            r_state     <= S_REQ;
                            r_cnt       <= '0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= in_store;
                            r_mem_addr  <= {in_addr[AW-1:2], 2'b00};
                            r_mem_wdata <= w_wdata;
                            r_mem_wstrb <= in_store ? w_wstrb : 4'b0000;
                            r_f3        <= in_funct3;
                            r_off       <= in_addr[1:0];
                            r_rd        <= in_rd;
                            r_addr      <= in_addr;
                        end else begin
                            r_err_valid <= 1'b1;
                            r_err_cause <= w_cause;
                            r_err_addr  <= in_addr;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_state     <= S_IDLE;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_wstrb <= 4'b0000;
                        if (!r_mem_we) begin
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= w_ldata;
                            r_wb_rd    <= r_rd;
                        end
                    end else if (w_expire) begin
                        r_state     <= S_IDLE;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_wstrb <= 4'b0000;
                        r_err_valid <= 1'b1;
                        r_err_cause <= ERR_TIMEOUT;
                        r_err_addr  <= r_addr;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign err_valid = r_err_valid;
    assign err_cause = r_err_cause;
    assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu (TIMEOUT=4): stores, load extension, misalignment,
// illegal ops, bus timeout and reset during an outstanding request.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_store;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err_valid;
    logic [1:0]  err_cause;
    logic [31:0] err_addr;

    int checks = 0;
    int errors = 0;

    // observation record filled by observe()
    int          ob_req, ob_wb, ob_err, ob_done, ob_busy;
    logic [31:0] ob_addr, ob_wdata, ob_wbd, ob_eaddr;
    logic [3:0]  ob_strb;
    logic        ob_we, ob_stable;
    logic [4:0]  ob_rd;
    logic [1:0]  ob_cause;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT(4), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_store(in_store),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_funct3(in_funct3), .in_rd(in_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .err_valid(err_valid), .err_cause(err_cause), .err_addr(err_addr)
    );

    // Presents one op for a single accept edge; returns at the negedge of cycle 1.
    task automatic issue(input logic st, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3, input logic [4:0] rd);
        @(negedge clk);
        in_valid  = 1'b1;
        in_store  = st;
        in_addr   = addr;
        in_wdata  = wd;
        in_funct3 = f3;
        in_rd     = rd;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Watches 10 cycles after issue; acks on request cycle ack_n (0 = never).
    task automatic observe(input int ack_n, input logic [31:0] rdata);
        ob_req = 0; ob_wb = 0; ob_err = 0; ob_done = 0; ob_busy = 0;
        ob_stable = 1'b1; ob_addr = '0; ob_wdata = '0; ob_strb = '0; ob_we = 1'b0;
        ob_wbd = '0; ob_rd = '0; ob_eaddr = '0; ob_cause = '0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_req) begin
                ob_req++;
                if (ob_req == 1) begin
                    ob_addr = mem_addr; ob_wdata = mem_wdata; ob_strb = mem_wstrb; ob_we = mem_we;
                end else if (mem_addr !== ob_addr || mem_wdata !== ob_wdata ||
                             mem_wstrb !== ob_strb || mem_we !== ob_we) begin
                    ob_stable = 1'b0;
                end
                if (in_ready) ob_busy++;
                mem_ack   = (ob_req == ack_n);
                mem_rdata = rdata;
            end else begin
                mem_ack = 1'b0;
            end
            if (in_ready && ob_done == 0) ob_done = c;
            if (wb_valid) begin
                ob_wb++; ob_wbd = wb_data; ob_rd = wb_rd;
            end
            if (err_valid) begin
                ob_err++; ob_cause = err_cause; ob_eaddr = err_addr;
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; in_store = 0; in_addr = '0; in_wdata = '0; in_funct3 = '0; in_rd = '0;
        mem_ack = 0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 4'b0 ||
            wb_valid !== 1'b0 || err_valid !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
            wb_data !== 32'h0 || wb_rd !== 5'd0 || err_cause !== 2'b00 || err_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b req=%b we=%b strb=%b wb=%b err=%b addr=%h wd=%h wbd=%h ea=%h, expected rdy=1 and all else 0",
                     in_ready, mem_req, mem_we, mem_wstrb, wb_valid, err_valid, mem_addr, mem_wdata, wb_data, err_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_store_word();
        issue(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 5'd0);
        observe(3, 32'h0);
        checks++;
        if (ob_req !== 3) begin errors++; $display("FAIL sw_req_cycles: got %0d expected 3", ob_req); end
        checks++;
        if (ob_addr !== 32'h100 || ob_wdata !== 32'hDEADBEEF || ob_strb !== 4'b1111 || ob_we !== 1'b1) begin
            errors++;
            $display("FAIL sw_bus: got addr=%h wd=%h strb=%b we=%b expected 00000100 deadbeef 1111 1",
                     ob_addr, ob_wdata, ob_strb, ob_we);
        end
        checks++;
        if (ob_stable !== 1'b1 || ob_busy !== 0) begin
            errors++; $display("FAIL sw_hold: got stable=%b ready_while_req=%0d expected 1 0", ob_stable, ob_busy);
        end
        checks++;
        if (ob_wb !== 0 || ob_err !== 0 || ob_done !== 4) begin
            errors++; $display("FAIL sw_done: got wb=%0d err=%0d ready_cycle=%0d expected 0 0 4", ob_wb, ob_err, ob_done);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3 [5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] ad [5]  = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h200};
        logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, ad[i], 32'h0, f3[i], 5'(i + 7));
            observe(1, 32'h80FF_7F01);
            checks++;
            if (ob_wb !== 1 || ob_wbd !== exp[i] || ob_rd !== 5'(i + 7)) begin
                errors++;
                $display("FAIL load_data[%0d]: got pulses=%0d data=%h rd=%0d expected 1 %h %0d",
                         i, ob_wb, ob_wbd, ob_rd, exp[i], i + 7);
            end
            checks++;
            if (ob_req !== 1 || ob_done !== 2 || ob_addr !== 32'h200 || ob_strb !== 4'b0 || ob_we !== 1'b0) begin
                errors++;
                $display("FAIL load_bus[%0d]: got req=%0d ready_cycle=%0d addr=%h strb=%b we=%b expected 1 2 00000200 0000 0",
                         i, ob_req, ob_done, ob_addr, ob_strb, ob_we);
            end
        end
    endtask

    task automatic test_store_lanes();
        issue(1'b1, 32'h302, 32'h1234_ABCD, 3'b001, 5'd0);
        observe(1, 32'h0);
        checks++;
        if (ob_addr !== 32'h300 || ob_wdata !== 32'hABCD_ABCD || ob_strb !== 4'b1100 || ob_wb !== 0) begin
            errors++;
            $display("FAIL sh_lanes: got addr=%h wd=%h strb=%b wb=%0d expected 00000300 abcdabcd 1100 0",
                     ob_addr, ob_wdata, ob_strb, ob_wb);
        end
        issue(1'b1, 32'h201, 32'h0000_00A5, 3'b000, 5'd0);
        observe(2, 32'h0);
        checks++;
        if (ob_addr !== 32'h200 || ob_wdata !== 32'hA5A5_A5A5 || ob_strb !== 4'b0010 || ob_req !== 2) begin
            errors++;
            $display("FAIL sb_lanes: got addr=%h wd=%h strb=%b req=%0d expected 00000200 a5a5a5a5 0010 2",
                     ob_addr, ob_wdata, ob_strb, ob_req);
        end
    endtask

    task automatic test_misaligned();
        logic        st  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3  [4] = '{3'b010, 3'b011, 3'b001, 3'b100};
        logic [31:0] ad  [4] = '{32'h105, 32'h100, 32'h301, 32'h100};
        logic [1:0]  exc [4] = '{2'b01, 2'b00, 2'b10, 2'b00};
        for (int i = 0; i < 4; i++) begin
            issue(st[i], ad[i], 32'h5555_5555, f3[i], 5'd1);
            observe(1, 32'h0);
            checks++;
            if (ob_err !== 1 || ob_cause !== exc[i] || ob_eaddr !== ad[i] || ob_req !== 0 ||
                ob_wb !== 0 || ob_done !== 1) begin
                errors++;
                $display("FAIL bad_op[%0d]: got err=%0d cause=%b addr=%h req=%0d wb=%0d ready_cycle=%0d expected 1 %b %h 0 0 1",
                         i, ob_err, ob_cause, ob_eaddr, ob_req, ob_wb, ob_done, exc[i], ad[i]);
            end
        end
    endtask

    task automatic test_timeout();
        issue(1'b0, 32'h440, 32'h0, 3'b010, 5'd9);
        observe(0, 32'h0);
        checks++;
        if (ob_req !== 4 || ob_err !== 1 || ob_cause !== 2'b11 || ob_eaddr !== 32'h440 ||
            ob_wb !== 0 || ob_done !== 5) begin
            errors++;
            $display("FAIL timeout: got req=%0d err=%0d cause=%b addr=%h wb=%0d ready_cycle=%0d expected 4 1 11 00000440 0 5",
                     ob_req, ob_err, ob_cause, ob_eaddr, ob_wb, ob_done);
        end
        issue(1'b0, 32'h440, 32'h0, 3'b010, 5'd9);
        observe(4, 32'hCAFE_F00D);
        checks++;
        if (ob_req !== 4 || ob_err !== 0 || ob_wb !== 1 || ob_wbd !== 32'hCAFE_F00D || ob_done !== 5) begin
            errors++;
            $display("FAIL ack_at_expiry: got req=%0d err=%0d wb=%0d data=%h ready_cycle=%0d expected 4 0 1 cafef00d 5",
                     ob_req, ob_err, ob_wb, ob_wbd, ob_done);
        end
    endtask

    task automatic test_reset_mid_req();
        int bad;
        issue(1'b0, 32'h40, 32'h0, 3'b010, 5'd3);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_pre: got req=%b rdy=%b expected 1 0", mem_req, in_ready);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222; rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || wb_valid !== 1'b0 || err_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_req: got req=%b wb=%b err=%b rdy=%b expected 0 0 0 1",
                     mem_req, wb_valid, err_valid, in_ready);
        end
        rst = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (wb_valid !== 1'b0 || mem_req !== 1'b0 || err_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        mem_ack = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL idle_ack_ignored: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_wrap();
        issue(1'b1, 32'hFFFF_FFFC, 32'h1122_3344, 3'b010, 5'd0);
        observe(1, 32'h0);
        checks++;
        if (ob_req !== 1 || ob_err !== 0 || ob_addr !== 32'hFFFF_FFFC || ob_strb !== 4'b1111) begin
            errors++;
            $display("FAIL wrap_word: got req=%0d err=%0d addr=%h strb=%b expected 1 0 fffffffc 1111",
                     ob_req, ob_err, ob_addr, ob_strb);
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_extend();
        test_store_lanes();
        test_misaligned();
        test_timeout();
        test_reset_mid_req();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
